alu_issue_sched: RTL and testbench

Issue scheduler for the ALU pool. Each cycle it selects up to NUM_ALU ready reservation-station entries from a request vector with a rotating-priority scan and binds each selected entry to a free (non-stalled) ALU. The bindings are registered as per-ALU issue slots, which drive each ALU's `rd_in` and its issue-packet mux select. The block sits between the reservation station and the ALU bank, and honours the per-ALU output stall driven by CDB arbitration.

---
 rtl/alu_issue_sched_if.sv | 28 ++
 rtl/alu_issue_sched.sv | 118 +++++++++++
 tb/tb_alu_issue_sched.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sched_if.sv
// Handshake bundle between the reservation station, the ALU issue scheduler
// and the ALU bank: requests/stalls in, grants and per-ALU issue slots out.
`timescale 1ns/1ps
interface alu_issue_sched_if #(
    parameter int NUM_REQ = 8,
    parameter int NUM_ALU = 3
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_ALU + 1);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_ALU-1:0]       alu_stall;
    logic                     squash;
    logic [NUM_REQ-1:0]       grant;
    logic [CNT_W-1:0]         grant_cnt;
    logic [NUM_ALU-1:0]       issue_valid;
    logic [NUM_ALU*IDX_W-1:0] issue_idx;

    modport master (
        output req, alu_stall, squash,
        input  grant, grant_cnt, issue_valid, issue_idx
    );

    modport slave (
        input  req, alu_stall, squash,
        output grant, grant_cnt, issue_valid, issue_idx
    );
endinterface

// File: rtl/alu_issue_sched.sv
// Rotating-priority issue scheduler: binds up to NUM_ALU ready RS entries to
// non-stalled ALUs each cycle and registers the bindings as per-ALU issue slots.
`timescale 1ns/1ps
module alu_issue_sched #(
    parameter int NUM_REQ = 8,
    parameter int NUM_ALU = 3
) (
    input logic clock,
    input logic reset_n,
    alu_issue_sched_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_ALU + 1);
    localparam int ALU_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_ALU-1:0] issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0] issue_idx_q [NUM_ALU];
    logic [IDX_W-1:0] issue_idx_d [NUM_ALU];

    logic [ALU_W-1:0] free_list [NUM_ALU];
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] bind_cnt;
    logic [ALU_W-1:0] alu_sel;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] last_idx;
    logic [NUM_REQ-1:0] grant_raw;
    logic [NUM_ALU-1:0] bound_valid;
    logic [IDX_W-1:0] bound_idx [NUM_ALU];
    logic issue_en;

    // Free ALUs are compacted into an ascending list so the j-th hit of the
    // scan simply takes list entry j.
    always_comb begin
        free_cnt = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            free_list[k] = '0;
        end
        for (int k = 0; k < NUM_ALU; k++) begin
            if (!bus.alu_stall[k]) begin
                free_list[free_cnt] = ALU_W'(k);
                free_cnt = free_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bind_cnt    = '0;
        alu_sel     = '0;
        scan_idx    = '0;
        last_idx    = rr_ptr_q;
        grant_raw   = '0;
        bound_valid = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            bound_idx[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            scan_idx = rr_ptr_q + IDX_W'(j);
            if (bus.req[scan_idx] && (bind_cnt < free_cnt)) begin
                alu_sel              = free_list[bind_cnt];
                bound_valid[alu_sel] = 1'b1;
                bound_idx[alu_sel]   = scan_idx;
                grant_raw[scan_idx]  = 1'b1;
                last_idx             = scan_idx;
                bind_cnt             = bind_cnt + CNT_W'(1);
            end
        end
    end

    // Grants are suppressed while flushing or held in reset; squash still
    // leaves the rotation pointer where it was.
    always_comb begin
        issue_en      = reset_n && !bus.squash;
        bus.grant     = issue_en ? grant_raw : '0;
        bus.grant_cnt = issue_en ? bind_cnt : '0;
        rr_ptr_d      = rr_ptr_q;
        if (issue_en && (bind_cnt != '0)) begin
            rr_ptr_d = last_idx + IDX_W'(1);
        end
        issue_valid_d = issue_valid_q;
        for (int k = 0; k < NUM_ALU; k++) begin
            issue_idx_d[k] = issue_idx_q[k];
            if (bus.squash) begin
                issue_valid_d[k] = 1'b0;
                issue_idx_d[k]   = '0;
            end else if (bus.alu_stall[k]) begin
                issue_valid_d[k] = issue_valid_q[k];
            end else if (bound_valid[k]) begin
                issue_valid_d[k] = 1'b1;
                issue_idx_d[k]   = bound_idx[k];
            end else begin
                issue_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            issue_valid_q <= '0;
            for (int k = 0; k < NUM_ALU; k++) begin
                issue_idx_q[k] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            for (int k = 0; k < NUM_ALU; k++) begin
                issue_idx_q[k] <= issue_idx_d[k];
            end
        end
    end

    assign bus.issue_valid = issue_valid_q;

    for (genvar k = 0; k < NUM_ALU; k++) begin : g_idx
        assign bus.issue_idx[k*IDX_W +: IDX_W] = issue_idx_q[k];
    end
endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched: directed scenarios plus a random
// phase, with a reference model feeding a scoreboard of expected slot states.
`timescale 1ns/1ps
module tb_alu_issue_sched;
    localparam int NUM_REQ = 8;
    localparam int NUM_ALU = 3;

    typedef struct packed {
        logic [2:0] valid;
        logic [8:0] idx;
        logic [2:0] rr;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_issue_sched_if #(.NUM_REQ(NUM_REQ), .NUM_ALU(NUM_ALU)) bus ();

    alu_issue_sched #(.NUM_REQ(NUM_REQ), .NUM_ALU(NUM_ALU)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checkCount = 0;
    int errorCount = 0;
    exp_t sb[$];

    logic [2:0] m_rr;
    logic [2:0] m_valid;
    logic [2:0] m_idx [3];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_rr = '0;
        m_valid = '0;
        for (int k = 0; k < 3; k++) m_idx[k] = '0;
    endtask

    // Drive one cycle of inputs, check the combinational grant against the
    // model, queue the expected slot state and compare it after the edge.
    task automatic applyStimulus(input logic [7:0] r, input logic [2:0] s, input logic sq);
        logic [7:0] eg;
        logic [1:0] ecnt;
        logic [2:0] bv;
        logic [2:0] bi [3];
        logic [2:0] last;
        int pos;
        exp_t e;
        bus.req = r;
        bus.alu_stall = s;
        bus.squash = sq;
        eg = '0;
        ecnt = '0;
        bv = '0;
        last = m_rr;
        pos = 0;
        for (int k = 0; k < 3; k++) begin
            bi[k] = '0;
            if (!s[k]) begin
                while (pos < NUM_REQ && !r[(int'(m_rr) + pos) % NUM_REQ]) pos++;
                if (pos < NUM_REQ) begin
                    bv[k] = 1'b1;
                    bi[k] = 3'((int'(m_rr) + pos) % NUM_REQ);
                    eg[bi[k]] = 1'b1;
                    last = bi[k];
                    ecnt = ecnt + 2'd1;
                    pos++;
                end
            end
        end
        if (sq) begin
            eg = '0;
            ecnt = '0;
        end
        #1;
        checkOutput("grant", 32'(bus.grant), 32'(eg));
        checkOutput("grant_cnt", 32'(bus.grant_cnt), 32'(ecnt));
        for (int k = 0; k < 3; k++) begin
            if (sq) begin
                m_valid[k] = 1'b0;
                m_idx[k] = '0;
            end else if (s[k]) begin
                m_valid[k] = m_valid[k];
            end else if (bv[k]) begin
                m_valid[k] = 1'b1;
                m_idx[k] = bi[k];
            end else begin
                m_valid[k] = 1'b0;
            end
        end
        if (!sq && ecnt != 0) m_rr = last + 3'd1;
        e.valid = m_valid;
        e.idx = {m_idx[2], m_idx[1], m_idx[0]};
        e.rr = m_rr;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checkOutput("issue_valid", 32'(bus.issue_valid), 32'(e.valid));
        checkOutput("issue_idx", 32'(bus.issue_idx), 32'(e.idx));
        checkOutput("rr_ptr", 32'(dut.rr_ptr_q), 32'(e.rr));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        bus.req = 8'hFF;
        bus.alu_stall = '0;
        bus.squash = 1'b0;
        #1;
        checkOutput("rst_grant", 32'(bus.grant), 32'h0);
        checkOutput("rst_cnt", 32'(bus.grant_cnt), 32'h0);
        checkOutput("rst_valid", 32'(bus.issue_valid), 32'h0);
        checkOutput("rst_idx", 32'(bus.issue_idx), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Basic allocation
        applyStimulus(8'b1010_0110, 3'b000, 1'b0);
        checkOutput("basic_valid", 32'(bus.issue_valid), 32'h7);
        checkOutput("basic_idx", 32'(bus.issue_idx), 32'({3'd5, 3'd2, 3'd1}));
        checkOutput("basic_rr", 32'(dut.rr_ptr_q), 32'd6);

        // Wrap-around, then the leftover entry 1
        applyStimulus(8'b1100_0011, 3'b000, 1'b0);
        checkOutput("wrap_idx", 32'(bus.issue_idx), 32'({3'd0, 3'd7, 3'd6}));
        checkOutput("wrap_rr", 32'(dut.rr_ptr_q), 32'd1);
        applyStimulus(8'b0000_0010, 3'b000, 1'b0);
        checkOutput("wrap_next_valid", 32'(bus.issue_valid), 32'h1);

        // Load ALU1 with idx 4 and bring the pointer to 0, then partial stall
        applyStimulus(8'b1001_0000, 3'b001, 1'b0);
        checkOutput("pre_stall_rr", 32'(dut.rr_ptr_q), 32'd0);
        applyStimulus(8'hFF, 3'b010, 1'b0);
        checkOutput("pstall_valid", 32'(bus.issue_valid), 32'h7);
        checkOutput("pstall_idx", 32'(bus.issue_idx), 32'({3'd1, 3'd4, 3'd0}));
        checkOutput("pstall_rr", 32'(dut.rr_ptr_q), 32'd2);

        // Squash clears every slot, including the stalled one
        applyStimulus(8'hFF, 3'b001, 1'b1);
        checkOutput("squash_valid", 32'(bus.issue_valid), 32'h0);
        checkOutput("squash_rr", 32'(dut.rr_ptr_q), 32'd2);

        // Full stall holds everything, then idle release
        applyStimulus(8'hFF, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) applyStimulus(8'hFF, 3'b111, 1'b0);
        checkOutput("fstall_valid", 32'(bus.issue_valid), 32'h7);
        checkOutput("fstall_rr", 32'(dut.rr_ptr_q), 32'd5);
        applyStimulus(8'h00, 3'b000, 1'b0);
        checkOutput("idle_valid", 32'(bus.issue_valid), 32'h0);

        // Async reset between edges
        applyStimulus(8'b0001_1000, 3'b010, 1'b0);
        checkOutput("pre_rst_valid", 32'(bus.issue_valid), 32'h5);
        checkOutput("pre_rst_rr", 32'(dut.rr_ptr_q), 32'd5);
        bus.req = 8'hFF;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("arst_valid", 32'(bus.issue_valid), 32'h0);
        checkOutput("arst_grant", 32'(bus.grant), 32'h0);
        checkOutput("arst_cnt", 32'(bus.grant_cnt), 32'h0);
        checkOutput("arst_rr", 32'(dut.rr_ptr_q), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(8'b0000_0001, 3'b000, 1'b0);
        checkOutput("post_rst_valid", 32'(bus.issue_valid), 32'h1);
        checkOutput("post_rst_idx", 32'(bus.issue_idx), 32'h0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [7:0] r;
            logic [2:0] s;
            logic sq;
            r = 8'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            sq = ($urandom_range(0, 15) == 0);
            applyStimulus(r, s, sq);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
